case_9_mul_pipe_ws: RTL and testbench

//  Parametrised, pipelined multiplier. Successor to the combinational fixed-width
//  HLS multiply core. Each operand can be signed or unsigned. Output is truncated
//  or saturated to dout_WIDTH, and an overflow flag travels with each result.
//  The core has NUM_STAGE register stages with valid/ready flow control and per-stage

---
 rtl/case_9_mul_pipe_ws.sv | 90 +++++++++
 tb/tb_case_9_mul_pipe_ws.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/case_9_mul_pipe_ws.sv
// Pipelined signed/unsigned multiplier with truncate-or-saturate output and an
// overflow flag, valid/ready flow control and per-stage bubble collapse.
module case_9_mul_pipe_ws #(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 3,
   parameter int din0_WIDTH  = 4,
   parameter int din1_WIDTH  = 3,
   parameter int dout_WIDTH  = 4,
   parameter int din0_SIGNED = 1,
   parameter int din1_SIGNED = 1,
   parameter int SAT_MODE    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int PW = din0_WIDTH + din1_WIDTH;
   localparam int XW = ((PW > dout_WIDTH) ? PW : dout_WIDTH) + 2;
   localparam bit RS = (din0_SIGNED != 0) || (din1_SIGNED != 0);

   localparam logic signed [XW-1:0] ONE = 1;
   localparam logic signed [XW-1:0] HI  = RS ? ((ONE <<< (dout_WIDTH-1)) - ONE)
                                             : ((ONE <<< dout_WIDTH) - ONE);
   localparam logic signed [XW-1:0] LO  = RS ? -(ONE <<< (dout_WIDTH-1)) : '0;

   logic [PW-1:0]            a_x, b_x, prod;
   logic signed [XW-1:0]     prod_x;
   logic [dout_WIDTH-1:0]    res;
   logic                     res_ovf;

   logic [NUM_STAGE:1]                 vld_pipe;
   logic [NUM_STAGE:1][dout_WIDTH-1:0] dat_pipe;
   logic [NUM_STAGE:1]                 ovf_pipe;
   logic [NUM_STAGE:1]                 adv;

   // The exact product always fits in PW bits, so a PW-bit multiply of the
   // extended operands is exact; only its interpretation depends on RS.
   always_comb begin
      a_x     = {{din1_WIDTH{(din0_SIGNED != 0) & din0[din0_WIDTH-1]}}, din0};
      b_x     = {{din0_WIDTH{(din1_SIGNED != 0) & din1[din1_WIDTH-1]}}, din1};
      prod    = a_x * b_x;
      prod_x  = {{(XW-PW){RS & prod[PW-1]}}, prod};
      res_ovf = (prod_x > HI) || (prod_x < LO);
      res     = prod_x[dout_WIDTH-1:0];
      if ((SAT_MODE != 0) && res_ovf)
         res = (prod_x > HI) ? HI[dout_WIDTH-1:0] : LO[dout_WIDTH-1:0];
   end

   // A stage may move when any stage at or after it holds a bubble, or the
   // output is being drained.
   for (genvar k = 1; k <= NUM_STAGE; k++) begin : g_adv
      assign adv[k] = out_ready | ~(&vld_pipe[NUM_STAGE:k]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
         ovf_pipe <= '0;
      end else if (ce) begin
         if (adv[1]) begin
            vld_pipe[1] <= in_valid;
            dat_pipe[1] <= res;
            ovf_pipe[1] <= res_ovf;
         end
         for (int k = 2; k <= NUM_STAGE; k++) begin
            if (adv[k]) begin
               vld_pipe[k] <= vld_pipe[k-1];
               dat_pipe[k] <= dat_pipe[k-1];
               ovf_pipe[k] <= ovf_pipe[k-1];
            end
         end
      end
   end

   assign in_ready  = ce & adv[1];
   assign out_valid = vld_pipe[NUM_STAGE];
   assign dout      = dat_pipe[NUM_STAGE];
   assign ovf       = ovf_pipe[NUM_STAGE];

endmodule

// File: tb/tb_case_9_mul_pipe_ws.sv
// Bench for case_9_mul_pipe_ws: several configurations share one stimulus stream,
// each scored against an integer-arithmetic model, plus directed scenarios.
module tb_case_9_mul_pipe_ws;

   localparam int NI = 8;
   localparam int NS_C  [NI] = '{3, 3, 3, 3, 3, 1, 5, 2};
   localparam int S0_C  [NI] = '{1, 1, 0, 0, 1, 0, 1, 1};
   localparam int S1_C  [NI] = '{1, 1, 0, 0, 0, 1, 1, 0};
   localparam int SAT_C [NI] = '{0, 1, 0, 1, 1, 0, 1, 0};
   localparam int DW_C  [NI] = '{4, 4, 4, 4, 4, 4, 4, 8};

   logic       clk, reset, ce, in_valid, out_ready;
   logic [3:0] din0;
   logic [2:0] din1;
   int         n_chk = 0, n_pass = 0;
   event       drain_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Exact integer product, then range check / wrap / clamp on the result width.
   function automatic logic [8:0] model(input logic [3:0] a, input logic [2:0] b,
                                        input int s0, input int s1, input int sat,
                                        input int dw);
      int av, bv, p, lo, hi, r;
      bit rs, ov;
      av = (s0 != 0) ? int'($signed(a)) : int'(a);
      bv = (s1 != 0) ? int'($signed(b)) : int'(b);
      p  = av * bv;
      rs = (s0 != 0) || (s1 != 0);
      lo = rs ? -(1 << (dw-1)) : 0;
      hi = rs ? (1 << (dw-1)) - 1 : (1 << dw) - 1;
      ov = (p < lo) || (p > hi);
      r  = ((sat != 0) && ov) ? ((p > hi) ? hi : lo) : p;
      r  = r & ((1 << dw) - 1);
      return {ov, r[7:0]};
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int DW = DW_C[g];
      logic [DW-1:0] d;
      logic          rdy, vo, ov;
      logic [8:0]    q[$];

      case_9_mul_pipe_ws #(
         .ID(g), .NUM_STAGE(NS_C[g]), .din0_WIDTH(4), .din1_WIDTH(3),
         .dout_WIDTH(DW), .din0_SIGNED(S0_C[g]), .din1_SIGNED(S1_C[g]),
         .SAT_MODE(SAT_C[g])
      ) u_dut (
         .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
         .in_valid(in_valid), .in_ready(rdy), .dout(d), .ovf(ov),
         .out_valid(vo), .out_ready(out_ready)
      );

      // Sampled mid-cycle: these are exactly the values the next edge acts on.
      always @(negedge clk) begin
         if (reset) q.delete();
         else begin
            if (vo && out_ready && ce) begin
               if (q.size() == 0) chk($sformatf("sb%0d_spurious", g), 1, 0);
               else chk($sformatf("sb%0d", g), int'({ov, 8'(d)}), int'(q.pop_front()));
            end
            if (in_valid && rdy)
               q.push_back(model(din0, din1, S0_C[g], S1_C[g], SAT_C[g], DW));
         end
      end

      always @(drain_done) chk($sformatf("drain%0d", g), q.size(), 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One op into an idle pipe; returns cycles from accept to out_valid on inst 0.
   task automatic op(input logic [3:0] a, input logic [2:0] b, output int lat);
      tick();
      din0 = a; din1 = b; in_valid = 1'b1;
      @(negedge clk);
      chk("op_in_ready", int'(g_dut[0].rdy), 1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (lat < 12) begin
         @(negedge clk);
         if (g_dut[0].vo) break;
         tick();
         lat++;
      end
   endtask

   int         lat, sent, got, gaps;
   logic [3:0] ra[6], hd;
   logic [2:0] rb[6];
   logic       hv, ho, held_set;

   initial begin
      reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      din0 = '0; din1 = '0;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", int'(g_dut[0].vo), 0);
      chk("rst_dout", int'(g_dut[0].d), 0);
      chk("rst_ovf", int'(g_dut[0].ov), 0);
      chk("rst_in_ready", int'(g_dut[0].rdy), 1);

      // Directed arithmetic cases; all NUM_STAGE=3 instances emit together.
      op(4'h7, 3'b101, lat);
      chk("t1_latency", lat, 3);
      chk("t1_wrap_dout", int'(g_dut[0].d), 'hB);
      chk("t1_wrap_ovf", int'(g_dut[0].ov), 1);
      chk("t2_sat_dout", int'(g_dut[1].d), 'h8);
      chk("t2_sat_ovf", int'(g_dut[1].ov), 1);
      op(4'h2, 3'b111, lat);
      chk("t1_neg_dout", int'(g_dut[0].d), 'hE);
      chk("t1_neg_ovf", int'(g_dut[0].ov), 0);
      op(4'h8, 3'b100, lat);
      chk("t2_minmin_sat", int'(g_dut[1].d), 'h7);
      chk("t2_minmin_ovf", int'(g_dut[1].ov), 1);
      chk("t2_minmin_wrap", int'(g_dut[0].d), 'h0);
      op(4'hF, 3'd7, lat);
      chk("t3_uns_wrap", int'(g_dut[2].d), 'h9);
      chk("t3_uns_ovf", int'(g_dut[2].ov), 1);
      chk("t3_uns_sat", int'(g_dut[3].d), 'hF);
      op(4'h8, 3'd7, lat);
      chk("t3_mixed_sat", int'(g_dut[4].d), 'h8);
      chk("t3_mixed_ovf", int'(g_dut[4].ov), 1);

      // Back-pressure: 3-deep pipe must absorb exactly 3 ops and hold its output.
      for (int i = 0; i < 6; i++) begin
         ra[i] = 4'($urandom); rb[i] = 3'($urandom);
      end
      tick();
      out_ready = 1'b0; sent = 0; held_set = 1'b0; hd = '0;
      for (int c = 0; c < 5; c++) begin
         din0 = ra[sent]; din1 = rb[sent]; in_valid = 1'b1;
         @(negedge clk);
         if (g_dut[0].rdy) sent++;
         if (g_dut[0].vo && !held_set) begin hd = g_dut[0].d; held_set = 1'b1; end
         tick();
      end
      @(negedge clk);
      chk("t4_accepts", sent, 3);
      chk("t4_in_ready_low", int'(g_dut[0].rdy), 0);
      chk("t4_out_valid", int'(g_dut[0].vo), 1);
      chk("t4_dout_held", int'(g_dut[0].d), int'(hd));
      tick();
      out_ready = 1'b1; got = 0; gaps = 0;
      for (int c = 0; c < 20 && got < 6; c++) begin
         if (sent < 6) begin din0 = ra[sent]; din1 = rb[sent]; in_valid = 1'b1; end
         else in_valid = 1'b0;
         @(negedge clk);
         if (in_valid && g_dut[0].rdy) sent++;
         if (g_dut[0].vo) got++;
         else gaps++;
         tick();
      end
      in_valid = 1'b0;
      chk("t4_delivered", got, 6);
      chk("t4_gaps", gaps, 0);

      // Clock-enable low for two cycles mid-stream.
      hv = 1'b0; hd = '0; ho = 1'b0;
      for (int c = 0; c < 10; c++) begin
         ce = !(c == 3 || c == 4);
         din0 = 4'($urandom); din1 = 3'($urandom);
         in_valid = (c < 6);
         @(negedge clk);
         if (c == 3) begin hv = g_dut[0].vo; hd = g_dut[0].d; ho = g_dut[0].ov; end
         if (!ce) chk("t5_in_ready", int'(g_dut[0].rdy), 0);
         if (c == 3) chk("t5_stream_live", int'(g_dut[0].vo), 1);
         if (c == 4) begin
            chk("t5_valid_held", int'(g_dut[0].vo), int'(hv));
            chk("t5_dout_held", int'(g_dut[0].d), int'(hd));
            chk("t5_ovf_held", int'(g_dut[0].ov), int'(ho));
         end
         tick();
      end
      ce = 1'b1; in_valid = 1'b0;

      // Reset with two ops in flight, then a fresh op's latency.
      din0 = 4'h7; din1 = 3'b101; in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_out_valid", int'(g_dut[0].vo), 0);
      chk("t6_dout", int'(g_dut[0].d), 0);
      chk("t6_ovf", int'(g_dut[0].ov), 0);
      op(4'h3, 3'b110, lat);
      chk("t6_latency", lat, 3);
      chk("t6_value", int'({g_dut[0].ov, 4'(g_dut[0].d)}),
          int'(model(4'h3, 3'b110, 1, 1, 0, 4)));

      // Random sweep across all configurations.
      for (int c = 0; c < 1500; c++) begin
         tick();
         ce        = ($urandom_range(0, 9) != 0);
         in_valid  = $urandom_range(0, 1) != 0;
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 199) == 0);
         din0      = 4'($urandom);
         din1      = 3'($urandom);
      end
      tick();
      ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; reset = 1'b0;
      for (int c = 0; c < 12; c++) tick();
      @(negedge clk);
      -> drain_done;
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
